imem_loader: RTL and testbench

- Boot-time writer for the instruction memory that the fetch stage reads.
- Accepts a byte stream over a valid/ready handshake. The stream is a 4-byte word-count header, N little-endian instruction words, then a 4-byte checksum trailer.
- Drives the instruction memory write port and holds the CPU in reset until a verified image is loaded.

---
 rtl/imem_loader_if.sv | 28 ++
 rtl/imem_loader.sv | 106 ++++++++++
 tb/tb_imem_loader.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot image loader.
// The loader is the slave; the boot source / memory side is the master.
interface imem_loader_if #(
    parameter int unsigned CPU_WIDTH   = 32,
    parameter int unsigned INSTR_WIDTH = 32
);
    logic                   start;
    logic [7:0]             byte_data;
    logic                   byte_valid;
    logic                   byte_ready;
    logic                   we;
    logic [CPU_WIDTH-1:0]   waddr;
    logic [INSTR_WIDTH-1:0] wdata;
    logic                   cpu_hold;
    logic                   done;
    logic                   err;
    logic [15:0]            words;

    modport master (
        output start, byte_data, byte_valid,
        input  byte_ready, we, waddr, wdata, cpu_hold, done, err, words
    );

    modport slave (
        input  start, byte_data, byte_valid,
        output byte_ready, we, waddr, wdata, cpu_hold, done, err, words
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: header (word count), N little-endian words,
// checksum trailer. Keeps the CPU held in reset until a verified image is written.
module imem_loader #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    imem_loader_if.slave bus
);
    typedef enum logic [2:0] {IDLE, HDR, DATA, CHK, DONE, ERR} state_t;

    state_t      state, state_nxt;
    logic [1:0]  bcnt;
    logic [31:0] shreg;
    logic [31:0] csum;
    logic [15:0] n;
    logic [15:0] words;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        done;
    logic        err;
    logic        hold;

    logic        accept;
    logic        group_done;
    logic        restart;
    logic [31:0] assembled;
    logic [31:0] n_ext;

    assign bus.byte_ready = (state == HDR) || (state == DATA) || (state == CHK);
    assign accept         = bus.byte_valid && bus.byte_ready;
    assign group_done     = accept && (bcnt == 2'd3);
    // Incoming byte lands on top; after four shifts the first byte sits in [7:0].
    assign assembled      = {bus.byte_data, shreg[31:8]};
    assign n_ext          = {16'h0000, assembled[15:0]};
    assign restart        = bus.start && ((state == IDLE) || (state == DONE) || (state == ERR));

    assign bus.we       = we;
    assign bus.waddr    = waddr;
    assign bus.wdata    = wdata;
    assign bus.done     = done;
    assign bus.err      = err;
    assign bus.cpu_hold = hold;
    assign bus.words    = words;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE, ERR: if (bus.start) state_nxt = HDR;
            HDR: if (group_done) begin
                if (n_ext > DEPTH_WORDS)          state_nxt = ERR;
                else if (assembled[15:0] == '0)   state_nxt = CHK;
                else                              state_nxt = DATA;
            end
            DATA: if (group_done && ((words + 16'd1) == n)) state_nxt = CHK;
            CHK: if (group_done) state_nxt = (assembled == csum) ? DONE : ERR;
            default: state_nxt = IDLE;
        endcase
    end

    // Word count and checksum update on the same edge that raises we, so the
    // trailer compare already includes the final word even when it overlaps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            bcnt  <= '0;
            shreg <= '0;
            csum  <= '0;
            n     <= '0;
            words <= '0;
            we    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
            hold  <= 1'b1;
        end else begin
            state <= state_nxt;
            we    <= 1'b0;
            done  <= (state_nxt == DONE);
            err   <= (state_nxt == ERR);
            hold  <= (state_nxt != DONE);
            if (restart) begin
                bcnt  <= '0;
                shreg <= '0;
                words <= '0;
                csum  <= '0;
            end else if (accept) begin
                bcnt  <= bcnt + 2'd1;
                shreg <= assembled;
                if (group_done && (state == HDR)) begin
                    n <= assembled[15:0];
                end
                if (group_done && (state == DATA)) begin
                    we    <= 1'b1;
                    wdata <= assembled;
                    waddr <= BASE_ADDR + {14'h0000, words, 2'b00};
                    words <= words + 16'd1;
                    csum  <= csum + assembled;
                end
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: default instance for normal loads, a DEPTH_WORDS=4
// instance (BASE_ADDR=0x100) for oversize and full-capacity images.
module tb_imem_loader;
    logic clk;
    logic rst;
    logic use_small;
    logic rdy;
    int   checks;
    int   errors;

    imem_loader_if bus ();
    imem_loader_if bus_s ();

    imem_loader dut (.clk(clk), .rst(rst), .bus(bus.slave));

    imem_loader #(.DEPTH_WORDS(4), .BASE_ADDR(32'h0000_0100)) dut_s (
        .clk(clk), .rst(rst), .bus(bus_s.slave)
    );

    assign bus_s.start      = bus.start;
    assign bus_s.byte_data  = bus.byte_data;
    assign bus_s.byte_valid = bus.byte_valid;
    assign rdy = use_small ? bus_s.byte_ready : bus.byte_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] wa [16];
    logic [31:0] wd [16];
    int          nw;
    int          nw_s;
    logic [31:0] last_wa_s;
    logic [31:0] last_wd_s;

    initial begin
        nw = 0;
        nw_s = 0;
        last_wa_s = '0;
        last_wd_s = '0;
    end

    always @(negedge clk) begin
        if (bus.we === 1'b1) begin
            if (nw < 16) begin
                wa[nw] = bus.waddr;
                wd[nw] = bus.wdata;
            end
            nw = nw + 1;
        end
        if (bus_s.we === 1'b1) begin
            last_wa_s = bus_s.waddr;
            last_wd_s = bus_s.wdata;
            nw_s = nw_s + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t;
        if (gaps && ($urandom_range(0, 1) == 1)) begin
            bus.byte_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        bus.byte_data  = b;
        bus.byte_valid = 1'b1;
        t = 0;
        while (!rdy && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!rdy) check("ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int unsigned i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], gaps);
        end
    endtask

    task automatic idle();
        bus.byte_valid = 1'b0;
        bus.byte_data  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    int n0;

    initial begin
        checks = 0;
        errors = 0;
        use_small = 1'b0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data = '0;
        repeat (2) @(negedge clk);

        check("rst_ready", 32'(bus.byte_ready), 32'd0);
        check("rst_we", 32'(bus.we), 32'd0);
        check("rst_waddr", bus.waddr, 32'd0);
        check("rst_wdata", bus.wdata, 32'd0);
        check("rst_hold", 32'(bus.cpu_hold), 32'd1);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_words", 32'(bus.words), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", 32'(bus.byte_ready), 32'd0);

        // Basic two-word load at full rate
        n0 = nw;
        pulse_start();
        check("hdr_ready", 32'(bus.byte_ready), 32'd1);
        send_word(32'd2, 0);
        send_word(32'h0000_0013, 0);
        send_word(32'h0010_0093, 0);
        send_word(32'h0010_00A6, 0);
        idle();
        check("basic_nw", 32'(nw - n0), 32'd2);
        check("basic_a0", wa[n0], 32'h0);
        check("basic_d0", wd[n0], 32'h0000_0013);
        check("basic_a1", wa[n0+1], 32'h4);
        check("basic_d1", wd[n0+1], 32'h0010_0093);
        check("basic_done", 32'(bus.done), 32'd1);
        check("basic_hold", 32'(bus.cpu_hold), 32'd0);
        check("basic_err", 32'(bus.err), 32'd0);
        check("basic_words", 32'(bus.words), 32'd2);
        check("basic_ready", 32'(bus.byte_ready), 32'd0);

        // Restart from DONE, then checksum mismatch
        pulse_start();
        check("restart_done", 32'(bus.done), 32'd0);
        check("restart_hold", 32'(bus.cpu_hold), 32'd1);
        check("restart_words", 32'(bus.words), 32'd0);
        n0 = nw;
        send_word(32'd2, 0);
        send_word(32'h0000_0013, 0);
        send_word(32'h0010_0093, 0);
        send_word(32'h0010_00A7, 0);
        idle();
        check("bad_err", 32'(bus.err), 32'd1);
        check("bad_done", 32'(bus.done), 32'd0);
        check("bad_hold", 32'(bus.cpu_hold), 32'd1);
        check("bad_nw", 32'(nw - n0), 32'd2);

        // Stalled stream from ERR
        pulse_start();
        check("err_cleared", 32'(bus.err), 32'd0);
        n0 = nw;
        send_word(32'd2, 1);
        send_word(32'h0000_0013, 1);
        send_word(32'h0010_0093, 1);
        send_word(32'h0010_00A6, 1);
        idle();
        check("stall_nw", 32'(nw - n0), 32'd2);
        check("stall_a0", wa[n0], 32'h0);
        check("stall_d0", wd[n0], 32'h0000_0013);
        check("stall_a1", wa[n0+1], 32'h4);
        check("stall_d1", wd[n0+1], 32'h0010_0093);
        check("stall_done", 32'(bus.done), 32'd1);
        check("stall_words", 32'(bus.words), 32'd2);

        // Empty image
        pulse_start();
        n0 = nw;
        send_word(32'd0, 0);
        send_word(32'd0, 0);
        idle();
        check("empty_done", 32'(bus.done), 32'd1);
        check("empty_nw", 32'(nw - n0), 32'd0);
        check("empty_hold", 32'(bus.cpu_hold), 32'd0);

        // Reset mid-DATA after the second word
        pulse_start();
        check("restart2_done", 32'(bus.done), 32'd0);
        check("restart2_hold", 32'(bus.cpu_hold), 32'd1);
        send_word(32'd3, 0);
        send_word(32'h1111_1111, 0);
        send_word(32'h2222_2222, 0);
        check("mid_we", 32'(bus.we), 32'd1);
        check("mid_words", 32'(bus.words), 32'd2);
        check("mid_wa", bus.waddr, 32'h4);
        rst = 1'b1;
        #1;
        check("mrst_we", 32'(bus.we), 32'd0);
        check("mrst_hold", 32'(bus.cpu_hold), 32'd1);
        check("mrst_words", 32'(bus.words), 32'd0);
        check("mrst_ready", 32'(bus.byte_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        n0 = nw;
        bus.byte_data = 8'h33;
        bus.byte_valid = 1'b1;
        repeat (8) @(negedge clk);
        idle();
        check("mrst_nowrite", 32'(nw - n0), 32'd0);
        check("mrst_ready2", 32'(bus.byte_ready), 32'd0);
        check("mrst_hold2", 32'(bus.cpu_hold), 32'd1);

        // Oversize header on the DEPTH_WORDS=4 instance
        use_small = 1'b1;
        n0 = nw_s;
        pulse_start();
        send_word(32'd5, 0);
        check("over_err", 32'(bus_s.err), 32'd1);
        check("over_ready", 32'(bus_s.byte_ready), 32'd0);
        repeat (4) @(negedge clk);
        idle();
        check("over_ready2", 32'(bus_s.byte_ready), 32'd0);
        check("over_nw", 32'(nw_s - n0), 32'd0);

        pulse_start();
        send_word(32'd1, 0);
        send_word(32'h1234_5678, 0);
        send_word(32'h1234_5678, 0);
        idle();
        check("one_done", 32'(bus_s.done), 32'd1);
        check("one_nw", 32'(nw_s - n0), 32'd1);
        check("one_wa", last_wa_s, 32'h0000_0100);
        check("one_wd", last_wd_s, 32'h1234_5678);

        // Full capacity: N == DEPTH_WORDS
        pulse_start();
        n0 = nw_s;
        send_word(32'd4, 0);
        for (int unsigned i = 1; i <= 4; i++) send_word(32'(i), 0);
        send_word(32'h0000_000A, 0);
        idle();
        check("full_done", 32'(bus_s.done), 32'd1);
        check("full_words", 32'(bus_s.words), 32'd4);
        check("full_nw", 32'(nw_s - n0), 32'd4);
        check("full_last_wa", last_wa_s, 32'h0000_010C);
        check("full_last_wd", last_wd_s, 32'h0000_0004);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
